// File: rtl/requant_unit.sv
// Requantiser: per-element signed multiply by scale, round-half-up shift, saturate to DW bits.
// Build option: define REQUANT_RELU_EN to zero negative results before saturation.
module requant_unit #(
   parameter int D_OUT   = 2,
   parameter int DW      = 4,
   parameter int ACC_W   = 10,
   parameter int SCALE_W = 8,
   parameter int SHIFT_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [D_OUT*ACC_W-1:0]   in_vec,
   input  logic [SCALE_W-1:0]       scale,
   input  logic [SHIFT_W-1:0]       shift,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [D_OUT*DW-1:0]      out_vec,
   output logic                     sat_flag,
   output logic                     drop_err
);

   localparam int          PROD_W   = ACC_W + SCALE_W + 1;
   localparam int unsigned PROD_W_U = PROD_W;
   localparam int          RW       = PROD_W + 1;
   localparam int          IDX_W    = (D_OUT > 1) ? $clog2(D_OUT) : 1;

   localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_HOLD
   } state_t;

   state_t                    state_q;
   logic [IDX_W-1:0]          idx_q;
   logic signed [ACC_W-1:0]   acc_q [D_OUT];
   logic [SCALE_W-1:0]        scale_q;
   logic [SHIFT_W-1:0]        shift_q;
   logic signed [DW-1:0]      out_q [D_OUT];
   logic                      in_ready_q;
   logic                      out_valid_q;
   logic                      sat_acc_q;
   logic                      sat_flag_q;
   logic                      drop_q;

   logic signed [PROD_W-1:0]  acc_ext_d;
   logic signed [PROD_W-1:0]  scl_ext_d;
   logic signed [PROD_W-1:0]  prod_d;
   logic signed [RW-1:0]      half_d;
   logic signed [RW-1:0]      sum_d;
   logic signed [RW-1:0]      rnd_d;
   logic signed [RW-1:0]      rl_d;
   logic signed [DW-1:0]      elem_d;
   logic                      elem_sat_d;

   // Datapath for the element selected by idx_q; the product is exact in PROD_W bits.
   always_comb begin
      acc_ext_d  = PROD_W'(acc_q[idx_q]);
      scl_ext_d  = PROD_W'($signed({1'b0, scale_q}));
      prod_d     = acc_ext_d * scl_ext_d;
      half_d     = '0;
      sum_d      = '0;
      rnd_d      = '0;
      rl_d       = '0;
      elem_d     = '0;
      elem_sat_d = 1'b0;

      if (shift_q == '0) begin
         rnd_d = RW'(prod_d);
      end else if (32'(shift_q) >= PROD_W_U) begin
         rnd_d = '0;
      end else begin
         half_d = RW'(1) << (shift_q - SHIFT_W'(1));
         sum_d  = RW'(prod_d) + half_d;
         rnd_d  = sum_d >>> shift_q;
      end

`ifdef REQUANT_RELU_EN
      if (rnd_d[RW-1]) begin
         rl_d = '0;
      end else begin
         rl_d = rnd_d;
      end
`else
      rl_d = rnd_d;
`endif

      if (rl_d > RW'(OUT_MAX)) begin
         elem_d     = OUT_MAX;
         elem_sat_d = 1'b1;
      end else if (rl_d < RW'(OUT_MIN)) begin
         elem_d     = OUT_MIN;
         elem_sat_d = 1'b1;
      end else begin
         elem_d = rl_d[DW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         scale_q     <= '0;
         shift_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         sat_acc_q   <= 1'b0;
         sat_flag_q  <= 1'b0;
         drop_q      <= 1'b0;
         for (int unsigned i = 0; i < D_OUT; i++) begin
            acc_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         // Any request outside IDLE is lost, including the handshake cycle of HOLD.
         if (in_valid && (state_q != S_IDLE)) begin
            drop_q <= 1'b1;
         end

         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  for (int unsigned i = 0; i < D_OUT; i++) begin
                     acc_q[i] <= in_vec[i*ACC_W +: ACC_W];
                  end
                  scale_q    <= scale;
                  shift_q    <= shift;
                  idx_q      <= '0;
                  sat_acc_q  <= 1'b0;
                  in_ready_q <= 1'b0;
                  state_q    <= S_CALC;
               end
            end

            S_CALC: begin
               out_q[idx_q] <= elem_d;
               sat_acc_q    <= sat_acc_q | elem_sat_d;
               if (idx_q == IDX_W'(D_OUT - 1)) begin
                  sat_flag_q  <= sat_acc_q | elem_sat_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_HOLD;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end

            S_HOLD: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < D_OUT; i++) begin
         out_vec[i*DW +: DW] = out_q[i];
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign sat_flag  = sat_flag_q;
   assign drop_err  = drop_q;

endmodule

// File: tb/tb_requant_unit.sv
// Bench for requant_unit: transaction-level reference model checked every cycle,
// directed literal cases, then randomized traffic with backpressure, drops and resets.
module tb_requant_unit;

   localparam int D_OUT   = 2;
   localparam int DW      = 4;
   localparam int ACC_W   = 10;
   localparam int SCALE_W = 8;
   localparam int SHIFT_W = 5;
   localparam int PROD_W  = ACC_W + SCALE_W + 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [D_OUT*ACC_W-1:0]   in_vec;
   logic [SCALE_W-1:0]       scale;
   logic [SHIFT_W-1:0]       shift;
   logic                     out_valid;
   logic                     out_ready;
   logic [D_OUT*DW-1:0]      out_vec;
   logic                     sat_flag;
   logic                     drop_err;

   always #5 clk = ~clk;

   requant_unit #(
      .D_OUT  (D_OUT),
      .DW     (DW),
      .ACC_W  (ACC_W),
      .SCALE_W(SCALE_W),
      .SHIFT_W(SHIFT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_vec   (in_vec),
      .scale    (scale),
      .shift    (shift),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_vec  (out_vec),
      .sat_flag (sat_flag),
      .drop_err (drop_err)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic on plain integers.
   function automatic int ref_elem(input int acc, input int sc, input int sh, inout bit sat);
      longint p;
      longint r;
      p = longint'(acc) * longint'(sc);
      if (sh == 0) r = p;
      else if (sh >= PROD_W) r = 0;
      else r = (p + (longint'(1) << (sh - 1))) >>> sh;
`ifdef REQUANT_RELU_EN
      if (r < 0) r = 0;
`endif
      if (r > longint'(2**(DW-1) - 1)) begin
         r = 2**(DW-1) - 1;
         sat = 1'b1;
      end else if (r < -longint'(2**(DW-1))) begin
         r = -(2**(DW-1));
         sat = 1'b1;
      end
      return int'(r);
   endfunction

   // Transaction-level model: idle -> D_OUT busy cycles -> valid until accepted.
   bit m_idle  = 1'b1;
   bit m_valid = 1'b0;
   bit m_drop  = 1'b0;
   bit m_sat   = 1'b0;
   int m_cnt   = 0;
   int m_vec  [D_OUT];
   int pend   [D_OUT];
   bit pend_sat;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle  = 1'b1;
         m_valid = 1'b0;
         m_drop  = 1'b0;
         m_sat   = 1'b0;
         m_cnt   = 0;
         foreach (m_vec[i]) m_vec[i] = 0;
      end else begin
         if (in_valid && !m_idle) m_drop = 1'b1;
         if (m_idle) begin
            if (in_valid) begin
               pend_sat = 1'b0;
               for (int i = 0; i < D_OUT; i++) begin
                  logic signed [ACC_W-1:0] a;
                  a = in_vec[i*ACC_W +: ACC_W];
                  pend[i] = ref_elem(int'(a), int'(scale), int'(shift), pend_sat);
               end
               m_idle = 1'b0;
               m_cnt  = 0;
            end
         end else if (m_valid) begin
            if (out_ready) begin
               m_valid = 1'b0;
               m_idle  = 1'b1;
            end
         end else begin
            m_cnt++;
            if (m_cnt == D_OUT) begin
               m_valid = 1'b1;
               m_vec   = pend;
               m_sat   = pend_sat;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_idle);
      chk("out_valid", out_valid, m_valid);
      chk("drop_err", drop_err, m_drop);
      chk("sat_flag", sat_flag, m_sat);
      if (m_valid) begin
         for (int i = 0; i < D_OUT; i++) begin
            chk($sformatf("out_vec[%0d]", i), $signed(out_vec[i*DW +: DW]), m_vec[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int a0, input int a1, input int sc, input int sh);
      in_vec   = {ACC_W'(a1), ACC_W'(a0)};
      scale    = SCALE_W'(sc);
      shift    = SHIFT_W'(sh);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_in_ready: timeout after %0d cycles, expected in_ready=1", n);
      end
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_out_valid: timeout after %0d cycles, expected out_valid=1", n);
      end
   endtask

   task automatic txn(input string nm, input int a0, input int a1, input int sc, input int sh,
                      input int e0, input int e1, input bit es);
      int lat;
      out_ready = 1'b0;
      wait_ready();
      pulse(a0, a1, sc, sh);
      wait_valid(lat);
      chk({nm, " latency"}, lat, D_OUT);
      chk({nm, " out_vec[0]"}, $signed(out_vec[DW-1:0]), e0);
      chk({nm, " out_vec[1]"}, $signed(out_vec[2*DW-1:DW]), e1);
      chk({nm, " sat_flag"}, sat_flag, es);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({nm, " in_ready after accept"}, in_ready, 1);
      chk({nm, " out_valid after accept"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit s;
      int lat;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_vec    = '0;
      scale     = '0;
      shift     = '0;
      rst       = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      chk("reset in_ready", in_ready, 1);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_vec", out_vec, 0);
      chk("reset sat_flag", sat_flag, 0);
      chk("reset drop_err", drop_err, 0);

      s = 1'b0;
      chk("model 6*1>>1", ref_elem(6, 1, 1, s), 3);
      s = 1'b0;
      chk("model 10*3>>2", ref_elem(10, 3, 2, s), 7);
      chk("model 10*3>>2 sat", s, 1);
      s = 1'b0;
      chk("model shift31", ref_elem(7, 1, 31, s), 0);

`ifdef REQUANT_RELU_EN
      s = 1'b0;
      chk("model relu -5>>1", ref_elem(-5, 1, 1, s), 0);
      txn("basic", 6, -5, 1, 1, 3, 0, 1'b0);
      txn("sat_hi_lo", 10, -40, 3, 2, 7, 0, 1'b1);
      txn("sat_none", 5, -5, 3, 2, 4, 0, 1'b0);
`else
      s = 1'b0;
      chk("model -5>>1", ref_elem(-5, 1, 1, s), -2);
      txn("basic", 6, -5, 1, 1, 3, -2, 1'b0);
      txn("sat_hi_lo", 10, -40, 3, 2, 7, -8, 1'b1);
      txn("sat_none", 5, -5, 3, 2, 4, -4, 1'b0);
`endif

      // Backpressure: hold, then a dropped pulse, then accept.
      wait_ready();
      pulse(1, -3, 2, 0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp out_valid", out_valid, 1);
         chk("bp in_ready", in_ready, 0);
         chk("bp out_vec[0]", $signed(out_vec[DW-1:0]), 2);
`ifdef REQUANT_RELU_EN
         chk("bp out_vec[1]", $signed(out_vec[2*DW-1:DW]), 0);
`else
         chk("bp out_vec[1]", $signed(out_vec[2*DW-1:DW]), -6);
`endif
      end
      pulse(5, 5, 1, 0);
      chk("bp drop_err", drop_err, 1);
      chk("bp out_vec after drop", $signed(out_vec[DW-1:0]), 2);
      chk("bp out_valid after drop", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp out_valid released", out_valid, 0);
      chk("bp in_ready released", in_ready, 1);

      // Reset while the second element is being processed.
      pulse(3, 3, 1, 0);
      tick();
      rst = 1'b1;
      #1;
      chk("midreset out_valid", out_valid, 0);
      chk("midreset out_vec", out_vec, 0);
      chk("midreset drop_err", drop_err, 0);
      tick();
      rst = 1'b0;
      chk("midreset in_ready", in_ready, 1);
      txn("post_reset", 2, 2, 2, 0, 4, 4, 1'b0);

`ifdef REQUANT_RELU_EN
      txn("shift0", 7, -8, 1, 0, 7, 0, 1'b0);
`else
      txn("shift0", 7, -8, 1, 0, 7, -8, 1'b0);
`endif
      txn("shift31", 7, -8, 1, 31, 0, 0, 1'b0);
      txn("shift_prodw", 511, -512, 255, PROD_W, 0, 0, 1'b0);

      // Randomized traffic; occasional resets clear the sticky drop flag.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         in_valid = m_idle ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 4) == 0)
            in_vec = {ACC_W'($urandom_range(0, 1) ? 511 : -512), ACC_W'($urandom)};
         else
            in_vec = {ACC_W'($urandom), ACC_W'($urandom)};
         scale     = SCALE_W'($urandom);
         shift     = ($urandom_range(0, 3) == 0) ? SHIFT_W'($urandom) : SHIFT_W'($urandom_range(0, 12));
         out_ready = ($urandom_range(0, 1) == 1);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
